// File: rtl/bch_dec_scheduler_if.sv
// Request / decoder / result bundle for bch_dec_scheduler.
// slave  : the scheduler side (requests in, decoder stream out, results out).
// master : the environment side (requesters, decoder core, result consumer).
interface bch_dec_scheduler_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
);
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [24*NUM_CH-1:0] req_syndrome;
  logic                 dec_in_valid;
  logic [3:0]           dec_in_syndrome;
  logic                 dec_out_valid;
  logic [3:0]           dec_out_location;
  logic                 res_valid;
  logic                 res_ready;
  logic [CH_W-1:0]      res_ch;
  logic [11:0]          res_location;
  logic                 res_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_syndrome, dec_out_valid, dec_out_location, res_ready,
    output req_ready, dec_in_valid, dec_in_syndrome, res_valid, res_ch,
           res_location, res_err, busy
  );

  modport master (
    output req_valid, req_syndrome, dec_out_valid, dec_out_location, res_ready,
    input  req_ready, dec_in_valid, dec_in_syndrome, res_valid, res_ch,
           res_location, res_err, busy
  );
endinterface

// File: rtl/bch_dec_scheduler.sv
// Round-robin scheduler sharing one BCH syndrome decoder among NUM_CH requesters.
// Ports: clk, rst (sync, active-high), bus (bch_dec_scheduler_if.slave):
//   req_*  per-channel 6-syndrome frame handshake
//   dec_*  serial syndrome stream to / location burst from the decoder
//   res_*  packed 3-location result with channel id and abort flag; busy
module bch_dec_scheduler #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  bch_dec_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, COLLECT, RESP} state_t;

  localparam logic [8:0]    TMO_LIM  = 9'(TIMEOUT);
  localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

  state_t          state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [23:0]     frame_q, frame_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [11:0]     loc_q, loc_d;
  logic            err_q, err_d;

  logic [NUM_CH-1:0] req_rot;
  logic              grant_found;
  logic [CH_W:0]     grant_off;
  logic [CH_W:0]     grant_sum;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W:0]     rr_sum;
  logic [CH_W-1:0]   rr_next;
  logic [23:0]       frame_sel;
  logic [8:0]        tmo_inc;

  // Arbiter: rotate requests so the rr pointer sits at bit 0, take the
  // lowest set bit, then rotate the winner's offset back to a channel id.
  always_comb begin
    req_rot     = NUM_CH'({bus.req_valid, bus.req_valid} >> rr_q);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_found && req_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = (CH_W+1)'(i);
      end
    end
    grant_sum = {1'b0, rr_q} + grant_off;
    grant_ch  = (grant_sum >= NUM_CH_X) ? CH_W'(grant_sum - NUM_CH_X) : CH_W'(grant_sum);
    rr_sum    = {1'b0, grant_ch} + (CH_W+1)'(1);
    rr_next   = (rr_sum == NUM_CH_X) ? '0 : CH_W'(rr_sum);
    frame_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_ch == CH_W'(i)) frame_sel = bus.req_syndrome[24*i +: 24];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    loc_d   = loc_q;
    err_d   = err_q;
    tmo_inc = {1'b0, tmo_q} + 9'd1;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          frame_d = frame_sel;
          ch_d    = grant_ch;
          rr_d    = rr_next;
          idx_d   = '0;
          err_d   = 1'b0;
          // Slots start as "no location" so a truncated burst needs no fill.
          loc_d   = '1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Frame is shifted out nibble 0 first; output taps frame_q[3:0].
        frame_d = {4'h0, frame_q[23:4]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd5) begin
          idx_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_inc[7:0];
        if (bus.dec_out_valid) begin
          loc_d[3:0] = bus.dec_out_location;
          idx_d      = 3'd1;
          state_d    = COLLECT;
        end else if (tmo_inc == TMO_LIM) begin
          loc_d   = '1;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      COLLECT: begin
        if (bus.dec_out_valid) begin
          if (idx_q == 3'd1) begin
            loc_d[7:4] = bus.dec_out_location;
            idx_d      = 3'd2;
          end else begin
            loc_d[11:8] = bus.dec_out_location;
            state_d     = RESP;
          end
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          tmo_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      loc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      loc_q   <= loc_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE && grant_found) ? (NUM_CH'(1) << grant_ch) : '0;
  assign bus.dec_in_valid    = (state_q == SEND);
  assign bus.dec_in_syndrome = (state_q == SEND) ? frame_q[3:0] : '0;
  assign bus.res_valid       = (state_q == RESP);
  assign bus.res_ch          = (state_q == RESP) ? ch_q : '0;
  assign bus.res_location    = (state_q == RESP) ? loc_q : '0;
  assign bus.res_err         = (state_q == RESP) ? err_q : 1'b0;
  assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_bch_dec_scheduler.sv
module tb_bch_dec_scheduler;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CH_W    = 1;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bch_dec_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  bch_dec_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [23:0] frame;
    int          nbeats;
    int          d;
    logic [11:0] locs;
    int          gcyc;
  } job_t;
  typedef struct {
    int          ch;
    logic [11:0] loc;
    logic        err;
    int          vcyc;
  } exp_t;
  typedef struct {
    int         cyc;
    logic [3:0] loc;
  } beat_t;

  job_t  dec_q[$];
  exp_t  exp_q[$];
  beat_t beat_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus knobs written by the main sequence
  int          remain[NUM_CH];
  bit          jitter      = 0;
  int          mode_sel    = 0;
  bit          frame_force = 0;
  logic [23:0] force_frame = '0;
  bit          locs_force  = 0;
  logic [11:0] force_locs  = '0;
  int          force_d     = -1;
  bit          ready_low   = 0;
  bit          ready_rand  = 0;

  // Reference model state
  bit in_flight = 0;
  int model_rr  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Input driver: all tb-driven signals change 1 time unit after the rising edge.
  initial begin
    bus.req_valid        = '0;
    bus.req_syndrome     = '0;
    bus.res_ready        = 1'b0;
    bus.dec_out_valid    = 1'b0;
    bus.dec_out_location = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        bus.req_valid[c] = (remain[c] > 0) && (!jitter || ($urandom % 4 != 0));
        bus.req_syndrome[24*c +: 24] = frame_force ? force_frame : 24'($urandom);
      end
      bus.res_ready        = ready_low ? 1'b0 : (ready_rand ? 1'($urandom % 2) : 1'b1);
      bus.dec_out_valid    = 1'b0;
      bus.dec_out_location = 4'($urandom);
      if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
        bus.dec_out_valid    = 1'b1;
        bus.dec_out_location = beat_q[0].loc;
        void'(beat_q.pop_front());
      end
    end
  end

  // Arbitration model: predicts req_ready/busy, issues jobs and expected results.
  initial begin : env
    int          g;
    int          c;
    int          r;
    int          keff;
    logic [NUM_CH-1:0] exp_ready;
    job_t        j;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 0;
        model_rr  = 0;
        exp_q.delete();
        dec_q.delete();
        beat_q.delete();
      end else begin
        g = -1;
        exp_ready = '0;
        if (!in_flight) begin
          for (int i = 0; i < NUM_CH; i++) begin
            c = (model_rr + i) % NUM_CH;
            if (g < 0 && bus.req_valid[c]) g = c;
          end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        check("busy", bus.busy, in_flight);
        if (in_flight) begin
          if (bus.res_valid && bus.res_ready) in_flight = 0;
        end else if (g >= 0) begin
          j.ch    = g;
          j.frame = bus.req_syndrome[24*g +: 24];
          j.gcyc  = cyc;
          j.locs  = locs_force ? force_locs : 12'($urandom);
          j.d     = int'($urandom % 16);
          r = mode_sel;
          if (r < 0) begin
            r = int'($urandom % 12);
            r = (r <= 6) ? 0 : r - 6;
          end
          case (r)
            1:       j.nbeats = 1;
            2:       j.nbeats = 2;
            3:       j.nbeats = 0;
            4:       begin j.nbeats = 3; j.d = TIMEOUT - 1; end
            5:       begin j.nbeats = 3; j.d = TIMEOUT; end
            default: j.nbeats = 3;
          endcase
          if (force_d >= 0) j.d = force_d;
          // A burst counts only if it starts within the TIMEOUT WAIT cycles.
          keff  = (j.d < TIMEOUT) ? j.nbeats : 0;
          e.ch  = g;
          e.loc = 12'hFFF;
          for (int k = 0; k < keff; k++) e.loc[4*k +: 4] = j.locs[4*k +: 4];
          e.err  = (keff < 3);
          e.vcyc = (keff == 0) ? j.gcyc + 7 + TIMEOUT
                               : j.gcyc + 8 + j.d + ((keff > 2) ? 2 : keff);
          dec_q.push_back(j);
          exp_q.push_back(e);
          remain[g] = remain[g] - 1;
          model_rr  = (g + 1) % NUM_CH;
          in_flight = 1;
        end
      end
    end
  end

  // Decoder model: checks the serial stream and schedules the location burst.
  initial begin : decoder
    int   nib;
    job_t j;
    beat_t b;
    nib = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nib = 0;
      end else if (bus.dec_in_valid) begin
        if (dec_q.size() == 0) begin
          check("dec_in_valid_unexpected", 32'(bus.dec_in_valid), 32'd0);
        end else begin
          j = dec_q[0];
          check("dec_in_syndrome", bus.dec_in_syndrome, j.frame[4*nib +: 4]);
          check("dec_in_cycle", cyc, j.gcyc + 1 + nib);
          nib++;
          if (nib == 6) begin
            nib = 0;
            for (int k = 0; k < j.nbeats; k++) begin
              b.cyc = j.gcyc + 7 + j.d + k;
              b.loc = j.locs[4*k +: 4];
              beat_q.push_back(b);
            end
            void'(dec_q.pop_front());
          end
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on each result handshake.
  initial begin : monitor
    bit   prev_v;
    exp_t e;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0;
      end else begin
        if (bus.res_valid) begin
          if (exp_q.size() == 0) begin
            check("res_valid_unexpected", 32'(bus.res_valid), 32'd0);
          end else begin
            e = exp_q[0];
            if (!prev_v) check("res_latency", cyc, e.vcyc);
            check("res_ch", bus.res_ch, e.ch);
            check("res_location", bus.res_location, e.loc);
            check("res_err", bus.res_err, e.err);
            if (bus.res_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = bus.res_valid && !bus.res_ready;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int left;
    int pend;
    left = budget;
    forever begin
      @(negedge clk);
      pend = 0;
      for (int c = 0; c < NUM_CH; c++) pend += remain[c];
      if (pend == 0 && !in_flight) break;
      left--;
      if (left == 0) begin
        n_chk++;
        $display("FAIL drain_%s: still busy after %0d cycles, required idle", tag, budget);
        for (int c = 0; c < NUM_CH; c++) remain[c] = 0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : main
    int n;
    for (int c = 0; c < NUM_CH; c++) remain[c] = 0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_dec_in_valid", bus.dec_in_valid, 0);
    check("rst_dec_in_syndrome", bus.dec_in_syndrome, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_ch", bus.res_ch, 0);
    check("rst_res_location", bus.res_location, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single directed frame
    frame_force = 1; force_frame = 24'h5A3F12;
    locs_force  = 1; force_locs  = 12'hF73;
    mode_sel = 0; force_d = 2;
    remain[0] = 1;
    wait_idle(300, "single");
    frame_force = 0; locs_force = 0; force_d = -1;

    // Fairness from reset
    do_reset();
    remain[0] = 2; remain[1] = 2;
    wait_idle(400, "fair");

    // Timeout, then a normal frame
    mode_sel = 3; remain[0] = 1;
    wait_idle(300, "timeout");
    mode_sel = 0; remain[1] = 1;
    wait_idle(300, "after_timeout");

    // Truncated bursts
    mode_sel = 1; locs_force = 1; force_locs = 12'h339; remain[1] = 1;
    wait_idle(300, "trunc1");
    locs_force = 0;
    mode_sel = 2; remain[0] = 1;
    wait_idle(300, "trunc2");

    // Answer on the last WAIT cycle, then one cycle too late
    mode_sel = 4; remain[0] = 1;
    wait_idle(300, "last_wait");
    mode_sel = 5; remain[1] = 1;
    wait_idle(300, "late");

    // Result backpressure with the other channel waiting
    mode_sel = 0; ready_low = 1;
    remain[0] = 1; remain[1] = 1;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      n_chk++;
      $display("FAIL backpressure_wait: res_valid 0 after 200 cycles, required 1");
    end
    repeat (10) @(negedge clk);
    ready_low = 0;
    wait_idle(300, "backpressure");

    // Reset during the third SEND cycle
    remain[0] = 1;
    n = 0;
    while (!in_flight && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_dec_in_valid", bus.dec_in_valid, 0);
    check("midrst_busy", bus.busy, 0);
    remain[0] = 1; remain[1] = 1;
    wait_idle(400, "after_reset");

    // Randomized traffic
    mode_sel = -1; jitter = 1; ready_rand = 1;
    remain[0] = 20; remain[1] = 20;
    wait_idle(20000, "random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bch_dec_scheduler.md
Name: bch_dec_scheduler

Overview:
Round-robin scheduler that shares one BCH syndrome decoder core (Euclidean key-equation solver plus Chien search, GF(2^4)) between NUM_CH requesters. Each requester hands over a complete 6-syndrome frame in one handshake. The scheduler serialises the frame into the decoder, collects the decoder's 3-location burst, and returns the packed result tagged with the channel id. A watchdog guards against a decoder that never answers.

Parameters:
NUM_CH, 2, number of requesting channels (2..4)
CH_W, 1, width of channel id; must equal clog2(NUM_CH), minimum 1
TIMEOUT, 64, max cycles in WAIT before the frame is aborted (range 8..255)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_CH  per-channel frame request
req_ready  output  NUM_CH  per-channel accept; at most one bit high (one-hot or zero)
req_syndrome  input  24*NUM_CH  channel c frame at [24c+23:24c]; nibble k (bits 4k+3:4k) is syndrome k, k=0..5, in exponent form (4'hF = zero element)
dec_in_valid  output  1  to decoder in_valid
dec_in_syndrome  output  4  to decoder in_syndrome
dec_out_valid  input  1  from decoder out_valid
dec_out_location  input  4  from decoder out_location (4'hF = no error)
res_valid  output  1  result available
res_ready  input  1  result consumer accept
res_ch  output  CH_W  channel that owns the result
res_location  output  12  locations; first received in [3:0], second in [7:4], third in [11:8]
res_err  output  1  frame aborted (timeout or truncated burst)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, all outputs 0, rr pointer=0 (channel 0 highest priority), timeout counter=0. Applies mid-frame: dec_in_valid is 0 from the next cycle, and the partial frame and result are discarded.
- States: IDLE -> SEND -> WAIT -> COLLECT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational, and only in IDLE: the highest-priority valid channel, searching from rr pointer upward with wrap.
  - On handshake, latch that channel's 24-bit frame and id, set rr pointer = granted+1 mod NUM_CH, go to SEND.
  - No req_valid: stay in IDLE.
- SEND: exactly 6 cycles, dec_in_valid=1, dec_in_syndrome = nibble 0..5 in order. First SEND cycle is the cycle after the grant. Then go to WAIT with dec_in_valid=0. IDLE always gives at least one in_valid-low gap between frames.
- WAIT:
  - Timeout counter increments each cycle.
  - dec_out_valid=1: capture dec_out_location into slot 0, go to COLLECT.
  - Counter reaches TIMEOUT with no out_valid: res_location=12'hFFF, res_err=1, go to RESP.
- COLLECT: the next 2 cycles fill slots 1 and 2.
  - If dec_out_valid=0 in either cycle, that slot and any remaining slots are 4'hF, res_err=1, go to RESP immediately.
  - After slot 2 is captured, go to RESP with res_err=0.
- RESP:
  - res_valid=1 with res_ch, res_location, res_err held stable until the cycle res_valid&res_ready.
  - That cycle: next state IDLE, res_valid=0 and timeout counter cleared.
  - No new grant is made while in RESP.
- dec_out_valid outside WAIT/COLLECT is ignored.
- Latency: grant at cycle T; dec_in_valid T+1..T+6. If the decoder answers at T+7+d, the result is valid at T+10+d (d≥0). Next grant no earlier than the cycle after the RESP handshake.
- req_valid of a non-granted channel may drop at any time without effect. Simultaneous requests are resolved only by the rr pointer.

Test Plan:
- Single request: ch0 frame 0x5A3F12, decoder model returns 3,7,F → dec_in_syndrome 2,1,F,3,A,5 on 6 consecutive cycles; res_location=12'hF73, res_ch=0, res_err=0.
- Fairness: both channels hold req_valid for 4 frames → grant order 0,1,0,1; after reset the first grant is ch0.
- Timeout: decoder never asserts out_valid → exactly 64 WAIT cycles, then res_valid with res_location=12'hFFF, res_err=1; the next frame proceeds normally.
- Truncated burst: out_valid high 1 cycle with location 9 → res_location=12'hFF9, res_err=1.
- Backpressure: res_ready held low 10 cycles → res_* stable, req_ready=0 throughout, single handshake on release.
- Reset at 3rd SEND cycle → dec_in_valid=0 next cycle, busy=0, rr pointer=0; a fresh request completes correctly.
